// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC sequencer: FSM state encoding, data
// width and the symmetric saturation limits.
package mac_pkg;

    localparam int DATA_W = 16;

    // Symmetric signed range: 0x8000 is never produced by the accumulator.
    localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] Q_MIN = 16'h8001;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        STROBE,
        ACC,
        DONE
    } state_t;

endpackage

// File: rtl/mac_sequencer_if.sv
// Handshake and multiplier bus of the MAC sequencer. The ovf flag exists only
// when MAC_OVF_STICKY_EN is defined.
interface mac_sequencer_if #(
    parameter int LEN_W = 8
);
    import mac_pkg::*;

    logic              start;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] mul_in1;
    logic [DATA_W-1:0] mul_in2;
    logic              mul_en;
    logic [DATA_W-1:0] mul_result;
    logic [DATA_W-1:0] acc_out;
    logic              busy;
    logic              done;
`ifdef MAC_OVF_STICKY_EN
    logic              ovf;
`endif

    // Master: the operand source and the external multiplier.
    modport master (
        output start, len, a_data, b_data, op_valid, mul_result,
        input  op_ready, mul_in1, mul_in2, mul_en, acc_out, busy, done
`ifdef MAC_OVF_STICKY_EN
        , input ovf
`endif
    );

    // Slave: the sequencer itself.
    modport slave (
        input  start, len, a_data, b_data, op_valid, mul_result,
        output op_ready, mul_in1, mul_in2, mul_en, acc_out, busy, done
`ifdef MAC_OVF_STICKY_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/sat_add16.sv
// 16-bit signed adder that saturates to the symmetric range [0x8001, 0x7FFF];
// sat flags any clipped result.
module sat_add16
    import mac_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum,
    output logic              sat
);

    localparam logic signed [DATA_W:0] POS_LIM = {1'b0, Q_MAX};
    localparam logic signed [DATA_W:0] NEG_LIM = {1'b1, Q_MIN};

    logic signed [DATA_W:0] wide;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        wide = $signed({a[DATA_W-1], a}) + $signed({b[DATA_W-1], b});
        sum  = wide[DATA_W-1:0];
        sat  = 1'b0;
        if (wide > POS_LIM) begin
            sum = Q_MAX;
            sat = 1'b1;
        end else if (wide < NEG_LIM) begin
            sum = Q_MIN;
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// Sequences len operand pairs through an external multiplier and accumulates
// the saturated products. Define MAC_OVF_STICKY_EN for the sticky ovf output.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    mac_sequencer_if.slave bus
);

    state_t            state;
    logic [LEN_W-1:0]  count;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] in1_q;
    logic [DATA_W-1:0] in2_q;
    logic              op_ready_q;
    logic              mul_en_q;
    logic              busy_q;
    logic              done_q;
    logic [DATA_W-1:0] acc_next;
    logic              acc_sat;

    sat_add16 u_sat_add (
        .a   (acc_q),
        .b   (bus.mul_result),
        .sum (acc_next),
        .sat (acc_sat)
    );

`ifdef MAC_OVF_STICKY_EN
    logic ovf_q;
    assign bus.ovf = ovf_q;
`else
    logic unused_sat;
    assign unused_sat = acc_sat;
`endif

    assign bus.op_ready = op_ready_q;
    assign bus.mul_en   = mul_en_q;
    assign bus.mul_in1  = in1_q;
    assign bus.mul_in2  = in2_q;
    assign bus.acc_out  = acc_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

    // Outputs are registered alongside the state so each is a clean flop.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            acc_q      <= '0;
            in1_q      <= '0;
            in2_q      <= '0;
            op_ready_q <= 1'b0;
            mul_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef MAC_OVF_STICKY_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            mul_en_q <= 1'b0;
            done_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        count  <= bus.len;
                        acc_q  <= '0;
                        busy_q <= 1'b1;
`ifdef MAC_OVF_STICKY_EN
                        ovf_q  <= 1'b0;
`endif
                        if (bus.len == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state      <= FETCH;
                            op_ready_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (bus.op_valid && op_ready_q) begin
                        in1_q      <= bus.a_data;
                        in2_q      <= bus.b_data;
                        op_ready_q <= 1'b0;
                        mul_en_q   <= 1'b1;
                        state      <= STROBE;
                    end
                end
                STROBE: begin
                    state <= ACC;
                end
                ACC: begin
                    acc_q <= acc_next;
                    count <= count - LEN_W'(1);
`ifdef MAC_OVF_STICKY_EN
                    ovf_q <= ovf_q | acc_sat;
`endif
                    if (count == LEN_W'(1)) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        state      <= FETCH;
                        op_ready_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy_q     <= 1'b0;
                    op_ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter LEN_W, default 8: width of the pair-count input len.
REQ-002 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: begin a MAC run; sampled only in IDLE.
REQ-005 SHALL have port len, input, LEN_W: number of operand pairs, latched on an accepted start.
REQ-006 SHALL have ports a_data and b_data, input, 16 each: signed operand pair.
REQ-007 SHALL have port op_valid, input, 1, and port op_ready, output, 1: operand handshake.
REQ-008 SHALL have ports mul_in1 and mul_in2, output, 16 each: registered operands driven to the multiplier.
REQ-009 SHALL have port mul_en, output, 1: multiplier strobe; the multiplier captures on its rising edge.
REQ-010 SHALL have port mul_result, input, 16: saturated signed product returned by the multiplier.
REQ-011 SHALL have port acc_out, output, 16: accumulator value.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-014 SHALL implement states IDLE, FETCH, STROBE, ACC and DONE.
REQ-015 In IDLE, start=1 SHALL latch len, clear acc_out to 0, and go to FETCH; if len=0, it SHALL go to DONE instead.
REQ-016 In FETCH, op_ready=1; on op_valid&&op_ready it SHALL register a_data/b_data into mul_in1/mul_in2 and go to STROBE; otherwise it SHALL hold FETCH indefinitely.
REQ-017 In STROBE, mul_en=1 for exactly one cycle, then the block SHALL go to ACC.
REQ-018 In ACC, acc_out SHALL be updated to sat(acc_out + mul_result) and the remaining count decremented; if the count was 1 the block SHALL go to DONE, else to FETCH.
REQ-019 In DONE, done=1 for one cycle, then the block SHALL go to IDLE; acc_out SHALL hold until the next accepted start.
REQ-020 mul_en SHALL be 0 in every state except STROBE, guaranteeing one rising edge per pair.
REQ-021 Latency, with op_valid held high: start sampled at edge 0 SHALL give done at edge 3N+1; a len=0 run SHALL give done at edge 1.
REQ-022 Saturation, with the sum computed at 17 bits signed: a sum >32767 SHALL give 0x7FFF; a sum <-32767 SHALL give 0x8001 (symmetric range, 0x8000 never produced).
REQ-023 start SHALL be ignored while busy=1; op_valid SHALL be ignored outside FETCH.
REQ-024 mul_in1/mul_in2 SHALL change only on an accepted handshake.

Reset
REQ-025 rst=1 SHALL force, at the next edge: state IDLE; acc_out, mul_in1, mul_in2 and the count to 0; mul_en, op_ready, busy, done and ovf (if present) to 0.
REQ-026 rst SHALL take priority over all other inputs, including mid-run in any state.

Configuration
REQ-027 With MAC_OVF_STICKY_EN defined, the block SHALL have output ovf, 1 bit, set when any ACC-state sum saturates, held through DONE, and cleared on an accepted start or on rst.
REQ-028 Without MAC_OVF_STICKY_EN, the ovf port and its logic SHALL be absent; saturation behaviour SHALL be unchanged.

Structure
REQ-029 Shared package mac_pkg SHALL hold the state enum, Q_MAX=16'h7FFF, Q_MIN=16'h8001 and the data width constant 16.
REQ-030 The saturating adder SHALL be a sub-module sat_add16 (inputs a, b; outputs sum, sat).

Verification
REQ-031 len=1, a=b=0x0200, model returns 0x0200 -> exactly one mul_en pulse at edge 2, acc_out=0x0200, done at edge 4.
REQ-032 len=3, model returns 0x4000 each pair -> acc_out 0x4000, 0x7FFF, 0x7FFF; done at edge 10; ovf=1 when enabled.
REQ-033 len=2, model returns 0xC000 each pair -> acc_out 0xC000, then 0x8001; ovf=1 when enabled.
REQ-034 len=0 -> done at edge 1, acc_out=0x0000, mul_en never asserted.
REQ-035 len=1 with op_valid withheld 5 cycles in FETCH -> op_ready stays 1, mul_en stays 0, done at edge 9.
REQ-036 rst asserted during STROBE of a len=4 run -> next edge busy=0, mul_en=0, acc_out=0; a new start with len=1 then completes normally.
